// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: shares one 16:1 selection datapath between 16 channels.
// Channels are served in round-robin order. The selected word goes to a
// single registered valid/ready output port.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst        - synchronous, active-high reset
//   req[15:0]  - per-channel request; req[i]=1 means data slice i is valid
//   data       - 16 channel words, flattened; channel i at data[i*WIDTH +: WIDTH]
//   gnt[15:0]  - one-hot acknowledge, combinational; high in the capture cycle
//   out_valid  - output register holds a word
//   out_ready  - downstream accepts the word when out_valid && out_ready
//   out_data   - captured word
//   out_sel    - channel index of out_data
//
// The file also contains mux16, the single-bit 16:1 selector. The datapath
// uses one mux16 instance per data bit.

// mux16: single-bit 16:1 multiplexer.
//   in[15:0] - candidate bits
//   sel[3:0] - index of the bit to pass
//   y        - selected bit
module mux16 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        y
);
  assign y = in[sel];
endmodule

module mux16_rr_sched #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           req,
  input  logic [16*WIDTH-1:0]   data,
  output logic [15:0]           gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [3:0]            out_sel
);

  logic [3:0]       ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [3:0]       out_sel_reg;

  logic [3:0]       winner;
  logic             found;
  logic [3:0]       idx;
  logic             load;
  logic [WIDTH-1:0] sel_word;

  // Search ptr, ptr+1, ... ptr+15. The 4-bit addition wraps mod 16.
  // The first requester in that order wins.
  always_comb begin
    winner = ptr_reg;
    found  = 1'b0;
    idx    = ptr_reg;
    for (int k = 0; k < 16; k++) begin
      idx = ptr_reg + k[3:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // A capture happens when the output slot is free or is being emptied on
  // this edge. Reset blocks captures, so gnt stays zero during reset.
  assign load = found && (!out_valid_reg || out_ready) && !rst;
  assign gnt  = load ? (16'd1 << winner) : 16'd0;

  // Datapath: one mux16 per bit position. The select is shared.
  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [15:0] slice;
      for (gj = 0; gj < 16; gj++) begin : g_ch
        assign slice[gj] = data[gj*WIDTH + gi];
      end
      mux16 u_mux16 (
        .in  (slice),
        .sel (winner),
        .y   (sel_word[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= 4'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= 4'd0;
    end else if (load) begin
      // When the block is already full, this edge also transfers the held
      // word out. The capture simply overwrites it.
      out_data_reg  <= sel_word;
      out_sel_reg   <= winner;
      out_valid_reg <= 1'b1;
      ptr_reg       <= winner + 4'd1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: doc/mux16_rr_sched.md
# mux16_rr_sched

Round-robin scheduler that shares one 16:1 selection datapath between 16 requesting channels and presents the selected word on a single valid/ready output port. Each cycle it picks the next requesting channel after the last one served. It drives the select index, captures the selected word into an output register and acknowledges the winner with a one-hot grant. The data path is built from WIDTH instances of the existing `mux16`, one per bit; bit b of channel i drives `in[i]` of instance b. The scheduler owns the 4-bit select.

## Interface
- WIDTH, 8, bits per channel data word (1..64)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  16  per-channel request; req[i]=1 means data slice i holds a valid word
- data  input  16*WIDTH  channel words, flattened; channel i at data[i*WIDTH +: WIDTH]
- gnt  output  16  one-hot acknowledge, combinational; gnt[i]=1 in the cycle channel i's word is captured
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts the word when out_valid && out_ready
- out_data  output  WIDTH  captured word
- out_sel  output  4  channel index of out_data

## Operation
- State is EMPTY (out_valid=0) or FULL (out_valid=1), plus a 4-bit round-robin pointer ptr.
- load = (|req) && (!out_valid || out_ready).
- Winner search (combinational): the first i with req[i]=1 in the order ptr, ptr+1, …, ptr+15, all mod 16. The search drives the mux16 select.
- On load at the clock edge:
  - out_data <= selected word
  - out_sel <= winner
  - out_valid <= 1
  - ptr <= winner+1 mod 16 (15 wraps to 0)
- gnt[winner]=1 during the load cycle only. gnt is all-zero when load=0.
- A requester treats req[i]&&gnt[i] at a clock edge as "word taken" and may present its next word or drop req in the following cycle.
- Without load: if out_valid && out_ready, then out_valid <= 0 (FULL -> EMPTY). Otherwise everything holds.
- FULL with out_ready=1 and a pending request: the word is transferred out and the next word is captured on the same edge. The block stays FULL.
- FULL with out_ready=0: no capture, gnt=0, ptr unchanged, out_data/out_sel stable.
- out_ready while EMPTY is ignored.
- Deasserting req on a channel that has not been granted has no effect on state.
- Reset values:
  - out_valid=0
  - out_data=0
  - out_sel=0
  - ptr=0
  - gnt=0 (no requests are acknowledged while rst=1)
- Reset during FULL discards the held word with no transfer. Arbitration restarts at channel 0.

## Timing
- Latency: req[i] high in cycle n (block EMPTY, i wins) -> gnt[i]=1 in cycle n -> out_valid=1 with the word in cycle n+1.
- Throughput: one word per cycle while out_ready=1 and at least one req is high.
- Fairness: a continuously requesting channel is granted within at most 16 loads (15 other grants between its own).
- No combinational path from out_ready to out_data/out_valid. gnt depends combinationally on req, ptr, out_valid and out_ready.
- The first edge with rst=0 may load.

## Test plan
- Reset: assert rst for 2 cycles with req=16'hFFFF and out_ready=1 -> gnt=0, out_valid=0, out_data=0, out_sel=0 throughout. First edge after release captures channel 0.
- Single requester: WIDTH=8, req=16'h0020, data slice 5=8'hA5, out_ready=1 -> gnt=16'h0020 in that cycle. Next cycle out_valid=1, out_data=8'hA5, out_sel=5. Then ptr=6.
- Round robin with wrap: req=16'h8003 held, out_ready=1, starting from ptr=0 -> out_sel sequence 0,1,15,0,1,15. Exactly one gnt bit per cycle.
- Backpressure: FULL with out_sel=3, out_ready=0 for 4 cycles, req=16'hFFFF -> gnt=0, out_data/out_sel stable, ptr=4 unchanged. Raise out_ready -> transfer plus capture of channel 4 on the same edge.
- Drain: one word held, req=0, out_ready=1 -> out_valid falls the next cycle. out_ready pulses while EMPTY cause no change.
- Mid-operation reset: FULL with out_sel=9 and ptr=10, pulse rst with req=16'h0401 -> out_valid=0. Next load grants channel 0, not channel 10.
